new_means_calc_sequencer: RTL and testbench
===========================================

Name: new_means_calc_sequencer

Overview:
Producer side of the new-centroid stream consumed by the convergence check. After each classification pass it divides the per-centroid coordinate sums by the per-centroid point counts. It then emits one new centroid per slot, in index order 0..7, with cent_num, divide_by_0 and a one-cycle valid strobe; the valid strobe drives the checker's convergence_reg_en. Seven coordinate divisions run in parallel, each on a serial restoring divider.

Parameters:
centroid_num, 8, number of centroids
cord_num, 7, coordinates per point
cordinate_width, 13, unsigned coordinate width
accum_cord_width, 22, unsigned per-coordinate sum width
accum_width, 7*22, one centroid's packed sums
count_width, 10, unsigned point count width
dataWidth, 91, packed centroid width (cord_num*cordinate_width)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
means_regs_reset_n  in  1  synchronous active-low clear, sampled on the clk edge; returns the block to IDLE
start  in  1  begin a run; sampled only in IDLE
accum_sums  in  centroid_num*accum_width  sums; centroid k at [k*accum_width +: accum_width]; coordinate j at bits [j*22 +: 22] of that field
counts  in  centroid_num*count_width  point counts; centroid k at [k*count_width +: count_width]
new_centroid_out  out  dataWidth  packed means; coordinate j at [j*13 +: 13]
cent_num  out  3  index of the emitted centroid
divide_by_0  out  1  count was zero for the emitted centroid
centroid_valid  out  1  one-cycle emit strobe, i.e. the checker's convergence_reg_en
busy  out  1  a run is in progress
done  out  1  one-cycle pulse after the centroid-7 emit

Behaviour:
- Reset (rst_n=0, async) or clear (means_regs_reset_n=0, sync): state IDLE, index 0, all outputs 0. Clear takes priority over start and over any FSM transition.
- FSM states: IDLE, LOAD, DIVIDE, EMIT, FINISH.
- IDLE, start=1: go to LOAD, index=0, busy=1.
- LOAD (1 cycle): select sums and count for the current index.
  - count==0: go to EMIT with quotient forced to 0 and divide_by_0=1.
  - Otherwise: launch all 7 dividers, go to DIVIDE.
- DIVIDE: lasts exactly accum_cord_width cycles (22), one quotient bit per cycle, MSB first, restoring.
- EMIT (1 cycle): registered outputs are valid in this cycle. centroid_valid=1, cent_num=index, new_centroid_out and divide_by_0 show the result.
  - If index<7: index+1, go to LOAD.
  - If index==7: go to FINISH.
- FINISH (1 cycle): done=1, busy=0, cent_num=0, then IDLE.
- Outside EMIT: centroid_valid=0, divide_by_0=0.
  - new_centroid_out and cent_num hold their last emitted values, except that cent_num returns to 0 in FINISH.
  - cent_num therefore equals 7 for exactly one cycle per run. This is mandatory: the checker evaluates convergence in any cycle where cent_num==7.
- Arithmetic: quotient = floor(sum/count), unsigned. A quotient >= 2^13 saturates to 13'h1FFF. The same count is shared by all 7 coordinates of a centroid.
- Latency: nonzero count gives 24 cycles per centroid (LOAD + 22 + EMIT); zero count gives 2 cycles. Centroid 0 valid occurs 24 cycles after the start-sampling edge. An all-nonzero run is 192 cycles to the last emit; done follows one cycle later.
- start while busy: ignored. start in the same cycle as clear: ignored.
- accum_sums and counts must be held stable from the start edge until done; they are not latched.
- Async reset mid-run: outputs drop to 0 immediately. The next start restarts at centroid 0.

Decomposition:
- Package kmeans_pkg:
  - width constants (cordinate_width, accum_cord_width, count_width, cord_num, centroid_num);
  - FSM state enum;
  - COORD_SAT = 13'h1FFF;
  - DIV_CYCLES = accum_cord_width.
- Sub-module serial_divider (22-bit dividend, 10-bit divisor, start/done), instantiated cord_num times. The sequencer owns the FSM, the operand select muxes and the saturation logic.

Test Plan:
1. All counts=1, sums = known coordinates -> 8 valid pulses 24 cycles apart, cent_num 0..7, data equals sums, divide_by_0=0; done one cycle after the cent_num=7 emit; busy low afterwards.
2. Centroid 0: count=3, coordinate 0 sum=10, coordinate 1 sum=2; centroid 1: count=1, sum=22'h3FFFFF -> coordinates 3 and 0; saturated 13'h1FFF.
3. counts[2]=0 -> centroid 2 emitted 2 cycles after its LOAD with divide_by_0=1 and data 0; the total run is 22 cycles shorter.
4. rst_n pulsed low mid-DIVIDE of centroid 4 -> all outputs 0 asynchronously, no done pulse; a new start re-emits from cent_num=0.
5. means_regs_reset_n=0 for one cycle during centroid 6 -> IDLE on the next edge, valid/done never asserted; start pulsed while busy has no effect on the timing of the run.
6. Full run monitored -> cent_num==7 in exactly one cycle, coincident with centroid_valid=1; centroid_valid is never high for 2 consecutive cycles.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared widths, FSM state type and saturation helper for the new-means
// sequencer and its serial dividers.
package kmeans_pkg;

  localparam int unsigned CENTROID_NUM = 8;
  localparam int unsigned CORD_NUM     = 7;
  localparam int unsigned CORD_W       = 13;
  localparam int unsigned ACCUM_CORD_W = 22;
  localparam int unsigned ACCUM_W      = CORD_NUM * ACCUM_CORD_W;
  localparam int unsigned COUNT_W      = 10;
  localparam int unsigned DATA_W       = CORD_NUM * CORD_W;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned DIV_CYCLES   = ACCUM_CORD_W;

  localparam logic [CORD_W-1:0] COORD_SAT = 13'h1FFF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DIVIDE = 3'd2,
    ST_EMIT   = 3'd3,
    ST_FINISH = 3'd4
  } seq_state_e;

  // Clamp a full-width quotient into one coordinate.
  function automatic logic [CORD_W-1:0] sat_coord(input logic [ACCUM_CORD_W-1:0] q);
    return (|q[ACCUM_CORD_W-1:CORD_W]) ? COORD_SAT : q[CORD_W-1:0];
  endfunction

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, MSB first.
// The first bit is resolved on the start edge, so done_o rises DIV_CYCLES-1 edges later.
module serial_divider
  import kmeans_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [ACCUM_CORD_W-1:0] dividend_i,
  input  logic [COUNT_W-1:0]      divisor_i,
  output logic [ACCUM_CORD_W-1:0] quotient_o,
  output logic                    done_o
);

  localparam int unsigned CNT_W = $clog2(DIV_CYCLES);

  logic [COUNT_W-1:0]      rem_q, rem_d;
  logic [ACCUM_CORD_W-1:0] dvd_q, dvd_d;
  logic [COUNT_W-1:0]      div_q, div_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    run_q, run_d;
  logic                    done_q, done_d;

  logic [COUNT_W-1:0]      src_rem;
  logic [ACCUM_CORD_W-1:0] src_dvd;
  logic [COUNT_W-1:0]      src_div;
  logic [COUNT_W:0]        trial;
  logic                    fits;
  logic [COUNT_W-1:0]      step_rem;
  logic [ACCUM_CORD_W-1:0] step_dvd;

  // One restoring step; on start the operands come straight from the inputs.
  always_comb begin
    src_rem  = start_i ? '0 : rem_q;
    src_dvd  = start_i ? dividend_i : dvd_q;
    src_div  = start_i ? divisor_i : div_q;
    trial    = {src_rem, src_dvd[ACCUM_CORD_W-1]};
    fits     = (trial >= {1'b0, src_div});
    step_rem = fits ? COUNT_W'(trial - {1'b0, src_div}) : trial[COUNT_W-1:0];
    step_dvd = {src_dvd[ACCUM_CORD_W-2:0], fits};
  end

  always_comb begin
    rem_d  = rem_q;
    dvd_d  = dvd_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = 1'b0;
    if (clear_i) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (start_i) begin
      rem_d = step_rem;
      dvd_d = step_dvd;
      div_d = divisor_i;
      cnt_d = CNT_W'(DIV_CYCLES - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      rem_d = step_rem;
      dvd_d = step_dvd;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dvd_q  <= '0;
      div_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvd_q  <= dvd_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign quotient_o = dvd_q;
  assign done_o     = done_q;

endmodule

// File: rtl/new_means_calc_sequencer.sv
// Divides per-centroid sums by point counts and streams the eight new
// centroids, in index order, to the convergence checker.
module new_means_calc_sequencer
  import kmeans_pkg::*;
(
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            means_regs_reset_n,
  input  logic                            start,
  input  logic [CENTROID_NUM*ACCUM_W-1:0] accum_sums,
  input  logic [CENTROID_NUM*COUNT_W-1:0] counts,
  output logic [DATA_W-1:0]               new_centroid_out,
  output logic [IDX_W-1:0]                cent_num,
  output logic                            divide_by_0,
  output logic                            centroid_valid,
  output logic                            busy,
  output logic                            done
);

  seq_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    cent_q, cent_d;
  logic                dbz_q, dbz_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [ACCUM_W-1:0]      sel_sums_c;
  logic [COUNT_W-1:0]      sel_count_c;
  logic                    count_zero_c;
  logic                    div_start_c;
  logic [CORD_NUM-1:0]     div_done;
  logic [ACCUM_CORD_W-1:0] quot [CORD_NUM];
  logic [DATA_W-1:0]       sat_data_c;

  // Operand select for the centroid currently being processed.
  always_comb begin
    sel_sums_c   = accum_sums[int'(idx_q)*ACCUM_W +: ACCUM_W];
    sel_count_c  = counts[int'(idx_q)*COUNT_W +: COUNT_W];
    count_zero_c = (sel_count_c == '0);
    div_start_c  = (state_q == ST_LOAD) && !count_zero_c && means_regs_reset_n;
  end

  for (genvar g = 0; g < CORD_NUM; g++) begin : g_div
    serial_divider u_div (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear_i    (!means_regs_reset_n),
      .start_i    (div_start_c),
      .dividend_i (sel_sums_c[g*ACCUM_CORD_W +: ACCUM_CORD_W]),
      .divisor_i  (sel_count_c),
      .quotient_o (quot[g]),
      .done_o     (div_done[g])
    );
  end

  always_comb begin
    sat_data_c = '0;
    for (int j = 0; j < CORD_NUM; j++) begin
      sat_data_c[j*CORD_W +: CORD_W] = sat_coord(quot[j]);
    end
  end

  // Next state and next registered outputs; the clear overrides everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    cent_d  = cent_q;
    dbz_d   = 1'b0;
    valid_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (count_zero_c) begin
          state_d = ST_EMIT;
          valid_d = 1'b1;
          cent_d  = idx_q;
          data_d  = '0;
          dbz_d   = 1'b1;
        end else begin
          state_d = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        if (&div_done) begin
          state_d = ST_EMIT;
          valid_d = 1'b1;
          cent_d  = idx_q;
          data_d  = sat_data_c;
        end
      end
      ST_EMIT: begin
        if (idx_q != IDX_W'(CENTROID_NUM - 1)) begin
          state_d = ST_LOAD;
          idx_d   = idx_q + IDX_W'(1);
        end else begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cent_d  = '0;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
    if (!means_regs_reset_n) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      data_d  = '0;
      cent_d  = '0;
      dbz_d   = 1'b0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
      cent_q  <= '0;
      dbz_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      cent_q  <= cent_d;
      dbz_q   <= dbz_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign new_centroid_out = data_q;
  assign cent_num         = cent_q;
  assign divide_by_0      = dbz_q;
  assign centroid_valid   = valid_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_new_means_calc_sequencer.sv
// Directed, table-driven bench for the new-means sequencer: per-centroid
// vectors with hand-computed quotients plus reset/clear corner sequences.
module tb_new_means_calc_sequencer;
  import kmeans_pkg::*;

  logic                            clk = 1'b0;
  logic                            rst_n = 1'b0;
  logic                            means_regs_reset_n = 1'b1;
  logic                            start = 1'b0;
  logic [CENTROID_NUM*ACCUM_W-1:0] accum_sums = '0;
  logic [CENTROID_NUM*COUNT_W-1:0] counts = '0;
  logic [DATA_W-1:0]               new_centroid_out;
  logic [IDX_W-1:0]                cent_num;
  logic                            divide_by_0;
  logic                            centroid_valid;
  logic                            busy;
  logic                            done;

  new_means_calc_sequencer dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .means_regs_reset_n (means_regs_reset_n),
    .start              (start),
    .accum_sums         (accum_sums),
    .counts             (counts),
    .new_centroid_out   (new_centroid_out),
    .cent_num           (cent_num),
    .divide_by_0        (divide_by_0),
    .centroid_valid     (centroid_valid),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [COUNT_W-1:0]      cnt;
    logic [ACCUM_CORD_W-1:0] s0;
    logic [ACCUM_CORD_W-1:0] s1;
    logic [CORD_W-1:0]       e0;
    logic [CORD_W-1:0]       e1;
    logic                    dbz;
  } cent_t;

  cent_t tab_a [CENTROID_NUM];
  cent_t tab_b [CENTROID_NUM];
  cent_t cur   [CENTROID_NUM];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic cent_t mk(input int cnt, input int s0, input int s1,
                               input int e0, input int e1, input bit dbz);
    cent_t c;
    c.cnt = COUNT_W'(cnt);
    c.s0  = ACCUM_CORD_W'(s0);
    c.s1  = ACCUM_CORD_W'(s1);
    c.e0  = CORD_W'(e0);
    c.e1  = CORD_W'(e1);
    c.dbz = dbz;
    return c;
  endfunction

  // Coordinates 2..6 use sum = cnt*v + (cnt-1), whose floor quotient is v.
  function automatic logic [ACCUM_CORD_W-1:0] sum_of(input int k, input int j);
    int c;
    c = int'(cur[k].cnt);
    if (j == 0) return cur[k].s0;
    if (j == 1) return cur[k].s1;
    if (c == 0) return ACCUM_CORD_W'(12345 + k);
    return ACCUM_CORD_W'(c * (100 * j + k) + c - 1);
  endfunction

  function automatic logic [CORD_W-1:0] exp_coord(input int k, input int j);
    if (j == 0) return cur[k].e0;
    if (j == 1) return cur[k].e1;
    if (cur[k].cnt == '0) return '0;
    return CORD_W'(100 * j + k);
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input int k);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int j = 0; j < CORD_NUM; j++) d[j*CORD_W +: CORD_W] = exp_coord(k, j);
    return d;
  endfunction

  task automatic apply_inputs();
    for (int k = 0; k < CENTROID_NUM; k++) begin
      counts[k*COUNT_W +: COUNT_W] = cur[k].cnt;
      for (int j = 0; j < CORD_NUM; j++)
        accum_sums[k*ACCUM_W + j*ACCUM_CORD_W +: ACCUM_CORD_W] = sum_of(k, j);
    end
  endtask

  // Pulse start; returns on the negedge of the LOAD cycle (cycle 1 of the run).
  task automatic kick();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full run of the cur table: data, index, flags and cycle position of every emit.
  task automatic run_table(input string name, input bit poke_start);
    int exp_t [CENTROID_NUM];
    int acc, n_emit, n_seven, done_t, n_double;
    logic prev_valid;
    acc = 0;
    for (int k = 0; k < CENTROID_NUM; k++) begin
      acc += (cur[k].cnt != '0) ? 24 : 2;
      exp_t[k] = acc;
    end
    apply_inputs();
    kick();
    n_emit = 0; n_seven = 0; done_t = -1; n_double = 0; prev_valid = 1'b0;
    chk($sformatf("%s busy_at_load", name), 96'(busy), 96'(1));
    for (int t = 1; t <= 230; t++) begin
      if (centroid_valid) begin
        if (n_emit < CENTROID_NUM) begin
          chk($sformatf("%s c%0d cent_num", name, n_emit), 96'(cent_num), 96'(n_emit));
          chk($sformatf("%s c%0d data", name, n_emit), 96'(new_centroid_out), 96'(exp_data(n_emit)));
          chk($sformatf("%s c%0d dbz", name, n_emit), 96'(divide_by_0), 96'(cur[n_emit].dbz));
          chk($sformatf("%s c%0d cycle", name, n_emit), 96'(t), 96'(exp_t[n_emit]));
        end
        n_emit++;
        if (prev_valid) n_double++;
      end
      if (cent_num == IDX_W'(7)) begin
        n_seven++;
        chk($sformatf("%s seven_with_valid", name), 96'(centroid_valid), 96'(1));
      end
      if (done && done_t < 0) done_t = t;
      prev_valid = centroid_valid;
      if (poke_start && t == 30) start = 1'b1;
      else start = 1'b0;
      @(negedge clk);
    end
    chk($sformatf("%s emit_count", name), 96'(n_emit), 96'(CENTROID_NUM));
    chk($sformatf("%s done_cycle", name), 96'(done_t), 96'(exp_t[CENTROID_NUM-1] + 1));
    chk($sformatf("%s seven_cycles", name), 96'(n_seven), 96'(1));
    chk($sformatf("%s back_to_back_valid", name), 96'(n_double), 96'(0));
    chk($sformatf("%s busy_after", name), 96'(busy), 96'(0));
  endtask

  // Idle window: nothing may be emitted or reported.
  task automatic quiet(input string name, input int cycles);
    int nv, nd, nb;
    nv = 0; nd = 0; nb = 0;
    for (int t = 0; t < cycles; t++) begin
      if (centroid_valid) nv++;
      if (done) nd++;
      if (busy) nb++;
      @(negedge clk);
    end
    chk($sformatf("%s no_valid", name), 96'(nv), 96'(0));
    chk($sformatf("%s no_done", name), 96'(nd), 96'(0));
    chk($sformatf("%s no_busy", name), 96'(nb), 96'(0));
  endtask

  task automatic chk_all_zero(input string name);
    chk($sformatf("%s data", name), 96'(new_centroid_out), 96'(0));
    chk($sformatf("%s cent_num", name), 96'(cent_num), 96'(0));
    chk($sformatf("%s valid", name), 96'(centroid_valid), 96'(0));
    chk($sformatf("%s dbz", name), 96'(divide_by_0), 96'(0));
    chk($sformatf("%s busy", name), 96'(busy), 96'(0));
    chk($sformatf("%s done", name), 96'(done), 96'(0));
  endtask

  initial begin
    for (int k = 0; k < CENTROID_NUM; k++)
      tab_a[k] = mk(1, k * 1000 + 7, 8191 - k, k * 1000 + 7, 8191 - k, 1'b0);
    tab_b[0] = mk(3,    10,        2,         3,      0,      1'b0);
    tab_b[1] = mk(1,    'h3FFFFF,  8192,      'h1FFF, 'h1FFF, 1'b0);
    tab_b[2] = mk(0,    500,       77,        0,      0,      1'b1);
    tab_b[3] = mk(1023, 'h3FFFFF,  1022,      4100,   0,      1'b0);
    tab_b[4] = mk(7,    100,       57343,     14,     8191,   1'b0);
    tab_b[5] = mk(2,    16383,     16384,     8191,   'h1FFF, 1'b0);
    tab_b[6] = mk(5,    0,         4,         0,      0,      1'b0);
    tab_b[7] = mk(10,   81920,     81919,     'h1FFF, 8191,   1'b0);

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_all_zero("post_reset");

    cur = tab_a;
    run_table("unit_counts", 1'b0);

    cur = tab_b;
    run_table("mixed", 1'b1);

    // Async reset in the middle of centroid 4's divide.
    cur = tab_a;
    apply_inputs();
    kick();
    repeat (105) @(negedge clk);
    chk("pre_rst cent_num", 96'(cent_num), 96'(3));
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet("after_rst", 40);
    run_table("restart", 1'b0);

    // Sync clear during centroid 6, with a start in the same cycle.
    cur = tab_a;
    apply_inputs();
    kick();
    repeat (148) @(negedge clk);
    chk("pre_clr busy", 96'(busy), 96'(1));
    means_regs_reset_n = 1'b0;
    start = 1'b1;
    @(negedge clk);
    means_regs_reset_n = 1'b1;
    start = 1'b0;
    chk_all_zero("sync_clr");
    quiet("after_clr", 60);

    cur = tab_b;
    run_table("after_clr_run", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
